muxf_rr_arbiter: RTL and testbench
==================================

# muxf_rr_arbiter

Round-robin arbiter and select sequencer for a shared wide multiplexer built from MUXF7/MUXF8 2:1 stages. It shares one output channel between NREQ requesters: it grants one requester at a time, holds the grant for a whole transfer, drives the encoded select for the mux tree, and registers the selected data beat. It sits in the simulation primitive library next to the mux primitives as the sequencing block for shared-resource models.

## Interface
- NREQ, 4, number of requesters; legal values 2, 4, 8 (mux-tree depth 1..3)
- DW, 8, data width per requester
- MAXBEAT, 0, maximum beats per grant before forced release; 0 = unlimited; legal 0..255

- C  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- CE  in  1  clock enable; 0 freezes all state and outputs
- REQ  in  NREQ  per-requester request / beat-valid
- LAST  in  NREQ  per-requester end-of-transfer flag, qualified by REQ of the same bit
- DI  in  NREQ*DW  requester data; requester i occupies bits [i*DW +: DW]
- GNT  out  NREQ  one-hot grant, all-zero when idle
- SEL  out  log2(NREQ)  binary select for the mux tree, equals index of GNT bit
- BUSY  out  1  high while a grant is held
- VLD  out  1  registered beat valid
- DO  out  DW  registered data of the granted requester

## Operation
- State machine, two states: IDLE (BUSY=0, GNT=0) and LOCK (BUSY=1, exactly one GNT bit set).
- Rotating pointer PTR holds the index of the last granted requester. On reset, PTR = NREQ-1, so requester 0 has first priority.
- IDLE, CE=1, REQ != 0: the winner is the first set REQ bit scanning PTR+1, PTR+2, ... modulo NREQ. Register GNT = one-hot(winner), SEL = winner, PTR = winner, beat counter BC = 0, and go to LOCK.
- IDLE with REQ = 0: stay in IDLE. GNT, SEL and PTR hold.
- LOCK, per cycle with CE=1:
  - A beat is REQ[SEL]=1.
  - On a beat: DO <= DI[SEL], VLD <= 1, BC <= BC+1 (8-bit, saturating).
  - Without a beat: VLD <= 0, DO holds. REQ[SEL]=0 pauses the transfer; the grant is kept.
- Release: a beat with LAST[SEL]=1, or with MAXBEAT != 0 and BC+1 == MAXBEAT. The state returns to IDLE and GNT clears at the same edge. PTR keeps the released index, so the next arbitration starts after it.
- A release cycle is followed by one mandatory IDLE cycle, used for arbitration, before the next grant.
- While in LOCK, REQ, LAST and DI of non-granted requesters are ignored. LAST without REQ is ignored.
- In the IDLE state with CE=1, VLD <= 0 and DO holds.
- SEL holds its last value in IDLE, so the mux tree output stays stable.
- CE=0: no state, PTR, BC, GNT, SEL, VLD or DO change, in any state.
- CLR asserted at any time, including mid-transfer: GNT=0, SEL=0, BUSY=0, VLD=0, DO=0, BC=0, PTR=NREQ-1, state IDLE. Takes effect immediately, without a clock edge. An in-flight transfer is dropped, not completed.

## Timing
- Reset values of outputs: GNT=0, SEL=0, BUSY=0, VLD=0, DO=0.
- Request to grant latency: 1 clock edge. REQ is sampled in IDLE at edge k, and GNT/SEL/BUSY are valid after edge k.
- Beat to output latency: 1 clock edge. A beat at edge k gives DO/VLD valid after edge k.
- The first beat can occur in the first LOCK cycle, if REQ[SEL] is still 1.
- Back-to-back transfers from different requesters: the minimum gap is 1 idle cycle (release edge, arbitration edge, then beats).
- Throughput for a single requester with LAST on every beat: 1 beat per 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert CLR mid-simulation, with REQ=0 and then REQ=4'b1111. Required: all outputs 0 during CLR. The first grant after release is requester 0: GNT=0001, SEL=0.
- Round-robin: NREQ=4 with REQ=1111 held and LAST=1111 on every cycle. Required grant order 0,1,2,3,0, one beat each, with BUSY low for 1 cycle between grants. DO carries the matching DI slice one edge after each beat.
- Lock and pause: requester 2 is granted, REQ[2] drops for 3 cycles with REQ[1] held, then a 4-beat burst ends with LAST. Required: GNT stays 0100 throughout, VLD is 0 for 3 cycles, DO shows all 4 beats in order, and requester 1 is granted 2 edges after the LAST beat.
- MAXBEAT=3: requester 0 streams with LAST=0 while requester 1 requests. Required: forced release after the 3rd beat, then GNT=0010 after the idle cycle.
- CE gating: toggle CE=0 for 2 cycles mid-burst, with REQ/DI changing. Required: GNT, SEL, DO, VLD and BC are frozen, and the beat count resumes unchanged after CE=1.
- Async reset mid-transfer: assert CLR between edges during a LOCK with VLD=1. Required: GNT, BUSY, VLD and DO go to 0 before the next edge, and priority restarts at requester 0.

Source files
------------

// File: rtl/muxf_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared MUXF7/MUXF8 mux tree.
// Grants one requester per transfer, drives the tree select and registers the selected beat.
module muxf_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int MAXBEAT = 0
) (
  input  logic                    C,
  input  logic                    CLR,
  input  logic                    CE,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ-1:0]         LAST,
  input  logic [NREQ*DW-1:0]      DI,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] SEL,
  output logic                    BUSY,
  output logic                    VLD,
  output logic [DW-1:0]           DO
);

  localparam int SW = $clog2(NREQ);
  localparam int unsigned NR = NREQ;

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] winner;
  logic [SW-1:0] idx;
  logic          found;
  logic [7:0]    bc;
  logic          beat;
  logic          max_hit;
  logic          rel;

  // Scan starts just after the last granted index; the pointer itself has lowest priority.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = ptr + SW'(i);
      if (!found && REQ[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign beat    = REQ[SEL];
  assign max_hit = (MAXBEAT != 0) && (({1'b0, bc} + 9'd1) == 9'(MAXBEAT));
  assign rel     = beat && (LAST[SEL] || max_hit);
  assign BUSY    = (state == S_LOCK);

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
      ptr   <= SW'(NREQ - 1);
      bc    <= '0;
      GNT   <= '0;
      SEL   <= '0;
      VLD   <= 1'b0;
      DO    <= '0;
    end else if (CE) begin
      case (state)
        S_IDLE: begin
          VLD <= 1'b0;
          if (|REQ) begin
            GNT   <= NREQ'(1) << winner;
            SEL   <= winner;
            ptr   <= winner;
            bc    <= '0;
            state <= S_LOCK;
          end
        end
        S_LOCK: begin
          VLD <= beat;
          if (beat) begin
            DO <= DI[SEL*DW +: DW];
            if (bc != '1) bc <= bc + 8'd1;
            if (rel) begin
              GNT   <= '0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muxf_rr_arbiter.sv
// Directed bench for muxf_rr_arbiter: instance a unlimited beats, instance b MAXBEAT=3,
// both on shared stimulus.
module tb_muxf_rr_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        ce;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] di;

  logic [3:0] a_gnt, b_gnt;
  logic [1:0] a_sel, b_sel;
  logic       a_busy, b_busy, a_vld, b_vld;
  logic [7:0] a_do, b_do;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muxf_rr_arbiter #(.NREQ(4), .DW(8), .MAXBEAT(0)) dut_a (
    .C(clk), .CLR(clr), .CE(ce), .REQ(req), .LAST(last), .DI(di),
    .GNT(a_gnt), .SEL(a_sel), .BUSY(a_busy), .VLD(a_vld), .DO(a_do)
  );

  muxf_rr_arbiter #(.NREQ(4), .DW(8), .MAXBEAT(3)) dut_b (
    .C(clk), .CLR(clr), .CE(ce), .REQ(req), .LAST(last), .DI(di),
    .GNT(b_gnt), .SEL(b_sel), .BUSY(b_busy), .VLD(b_vld), .DO(b_do)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_gnt"},  32'(a_gnt),  32'h0);
    chk({tag, "_a_sel"},  32'(a_sel),  32'h0);
    chk({tag, "_a_busy"}, 32'(a_busy), 32'h0);
    chk({tag, "_a_vld"},  32'(a_vld),  32'h0);
    chk({tag, "_a_do"},   32'(a_do),   32'h0);
    chk({tag, "_b_gnt"},  32'(b_gnt),  32'h0);
    chk({tag, "_b_busy"}, 32'(b_busy), 32'h0);
    chk({tag, "_b_vld"},  32'(b_vld),  32'h0);
    chk({tag, "_b_do"},   32'(b_do),   32'h0);
  endtask

  initial begin
    logic [7:0] rr_data [4];
    rr_data[0] = 8'h11; rr_data[1] = 8'h22; rr_data[2] = 8'h33; rr_data[3] = 8'h44;

    clr = 1'b1; ce = 1'b1; req = 4'b0000; last = 4'b0000; di = 32'h44332211;
    #2;
    chk_zero("rst_req0");
    req = 4'b1111;
    tick();
    tick();
    chk_zero("rst_req1111");
    clr  = 1'b0;
    last = 4'b1111;

    // Round robin: grant cycle then release beat, five transfers
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt",  32'(a_gnt),  32'(4'b0001 << (k % 4)));
      chk("rr_sel",  32'(a_sel),  32'(k % 4));
      chk("rr_busy", 32'(a_busy), 32'h1);
      chk("rr_vld0", 32'(a_vld),  32'h0);
      tick();
      chk("rr_gnt_rel", 32'(a_gnt),  32'h0);
      chk("rr_busy_rel", 32'(a_busy), 32'h0);
      chk("rr_vld1", 32'(a_vld),  32'h1);
      chk("rr_do",   32'(a_do),   32'(rr_data[k % 4]));
    end
    req = 4'b0000; last = 4'b0000;
    tick();

    // Lock and pause on requester 2
    req = 4'b0100;
    tick();
    chk("lp_gnt", 32'(a_gnt), 32'h4);
    chk("lp_sel", 32'(a_sel), 32'h2);
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lp_pause_gnt", 32'(a_gnt), 32'h4);
      chk("lp_pause_vld", 32'(a_vld), 32'h0);
      chk("lp_pause_do",  32'(a_do),  32'h11);
    end
    req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      di[23:16] = 8'hC0 + 8'(k);
      if (k == 3) last = 4'b0100;
      tick();
      chk("lp_beat_vld", 32'(a_vld), 32'h1);
      chk("lp_beat_do",  32'(a_do),  32'(8'hC0 + 8'(k)));
      chk("lp_beat_gnt", 32'(a_gnt), (k == 3) ? 32'h0 : 32'h4);
    end
    last = 4'b0000; req = 4'b0010;
    tick();
    chk("lp_next_gnt", 32'(a_gnt), 32'h2);
    chk("lp_next_sel", 32'(a_sel), 32'h1);

    // Clear between edges, then MAXBEAT=3 with a CE freeze mid-burst
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    req = 4'b0011; di = 32'h00000050;
    tick();
    chk("mb_gnt_b", 32'(b_gnt), 32'h1);
    tick();
    chk("mb_b1_do", 32'(b_do), 32'h50);
    di[7:0] = 8'h51;
    tick();
    chk("mb_b2_do",  32'(b_do),  32'h51);
    chk("mb_b2_gnt", 32'(b_gnt), 32'h1);
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req = (k == 0) ? 4'b0000 : 4'b1110;
      di  = 32'hFFFFFFFF;
      tick();
      chk("ce_gnt", 32'(b_gnt), 32'h1);
      chk("ce_sel", 32'(b_sel), 32'h0);
      chk("ce_vld", 32'(b_vld), 32'h1);
      chk("ce_do",  32'(b_do),  32'h51);
    end
    ce = 1'b1; req = 4'b0011; di = 32'h00000052;
    tick();
    chk("mb_rel_gnt",  32'(b_gnt),  32'h0);
    chk("mb_rel_busy", 32'(b_busy), 32'h0);
    chk("mb_rel_do",   32'(b_do),   32'h52);
    chk("mb_a_hold",   32'(a_gnt),  32'h1);
    di = 32'h0000AA52;
    tick();
    chk("mb_next_gnt", 32'(b_gnt), 32'h2);
    chk("mb_next_sel", 32'(b_sel), 32'h1);
    chk("mb_a_still",  32'(a_gnt), 32'h1);

    // Async reset mid-transfer with VLD high
    tick();
    chk("ar_a_vld", 32'(a_vld), 32'h1);
    chk("ar_b_vld", 32'(b_vld), 32'h1);
    chk("ar_b_do",  32'(b_do),  32'hAA);
    #2 clr = 1'b1;
    #1;
    chk_zero("ar_mid");
    clr = 1'b0; req = 4'b1111;
    tick();
    chk("ar_a_gnt", 32'(a_gnt), 32'h1);
    chk("ar_b_gnt", 32'(b_gnt), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
